// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg : shared types, defaults and helpers for pipeline_ctrl  |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package pipeline_pkg;

    localparam int NUM_STAGES_DEFAULT = 5;
    localparam int CNT_W_DEFAULT      = 16;
    localparam int c_MAX_STAGES       = 16;

    localparam int IF_STG  = 0;
    localparam int ID_STG  = 1;
    localparam int EXE_STG = 2;
    localparam int MEM_STG = 3;
    localparam int WB_STG  = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } step_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } hi_idx_t;

    // Highest set bit of a request vector; found=0 means "none".
    function automatic hi_idx_t highest_set(input logic [c_MAX_STAGES-1:0] vec);
        hi_idx_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < c_MAX_STAGES; i++) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_ctrl_if : request/control bundle between pipeline and ctrl  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface pipeline_ctrl_if
    import pipeline_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
);
    logic                  inst_valid;
    logic [NUM_STAGES-1:0] stall_req;
    logic [NUM_STAGES-1:0] flush_req;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output inst_valid, stall_req, flush_req,
        input  stage_en, stage_flush, stage_valid, stall_cycles, flush_count
    );

    modport slave (
        input  inst_valid, stall_req, flush_req,
        output stage_en, stage_flush, stage_valid, stall_cycles, flush_count
    );

endinterface
`default_nettype wire

// File: rtl/step_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | step_sync : 2-FF synchroniser + rising-edge detect for debug_step    |
// | Built only with DEBUG_STEP_EN.  Revision : 1.0                       |
// +----------------------------------------------------------------------+
`ifdef DEBUG_STEP_EN
module step_sync
    import pipeline_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_debug_step,
    output logic o_step_pulse
);
    logic [1:0] r_sync;
    logic       r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_debug_step};
            r_prev <= r_sync[1];
        end
    end

    assign o_step_pulse = r_sync[1] & ~r_prev;

endmodule
`endif
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_ctrl : stall/flush steering, occupancy and perf counters    |
// | Optional single-step support under macro DEBUG_STEP_EN. Rev : 1.0    |
// +----------------------------------------------------------------------+
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int NUM_STAGES = NUM_STAGES_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
`ifdef DEBUG_STEP_EN
    input  logic debug_en,
    input  logic debug_step,
`endif
    pipeline_ctrl_if.slave bus
);
    logic [c_MAX_STAGES-1:0] w_stall_ext;
    logic [c_MAX_STAGES-1:0] w_flush_ext;
    hi_idx_t                 w_s;
    hi_idx_t                 w_f;
    logic                    w_stall_mode;
    logic                    w_flush_mode;
    logic                    w_halted;
    logic                    w_stall_inc;
    logic                    w_flush_inc;
    logic [NUM_STAGES-1:0]   w_en;
    logic [NUM_STAGES-1:0]   w_flush;
    logic [NUM_STAGES-1:0]   w_valid_nxt;
    logic [NUM_STAGES-1:0]   r_valid;
    logic [CNT_W-1:0]        r_stall_cycles;
    logic [CNT_W-1:0]        r_flush_count;

    always_comb begin
        w_stall_ext = '0;
        w_flush_ext = '0;
        w_stall_ext[NUM_STAGES-1:0] = bus.stall_req;
        w_flush_ext[NUM_STAGES-1:0] = bus.flush_req;
    end

    assign w_s = highest_set(w_stall_ext);
    assign w_f = highest_set(w_flush_ext);

    // An older stall outranks a younger redirect; the redirect re-asserts once released.
    assign w_stall_mode = w_s.found && (!w_f.found || (w_s.idx > w_f.idx));
    assign w_flush_mode = w_f.found && !w_stall_mode;

`ifdef DEBUG_STEP_EN
    localparam logic [1:0] c_ST_RUN  = RUN;
    localparam logic [1:0] c_ST_HALT = HALT;
    localparam logic [1:0] c_ST_STEP = STEP;

    logic [1:0] r_state;
    logic       w_step_pulse;

    step_sync u_step_sync (
        .clk          (clk),
        .rst          (rst),
        .i_debug_step (debug_step),
        .o_step_pulse (w_step_pulse)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_RUN;
        end else begin
            case (r_state)
                c_ST_RUN:  if (debug_en) r_state <= c_ST_HALT;
                c_ST_HALT: begin
                    if (!debug_en)         r_state <= c_ST_RUN;
                    else if (w_step_pulse) r_state <= c_ST_STEP;
                end
                c_ST_STEP: r_state <= debug_en ? c_ST_HALT : c_ST_RUN;
                default:   r_state <= c_ST_RUN;
            endcase
        end
    end

    assign w_halted = (r_state == c_ST_HALT);
`else
    assign w_halted = 1'b0;
`endif

    always_comb begin
        w_en    = '1;
        w_flush = '0;
        if (!rst) begin
            w_en    = '0;
            w_flush = '1;
        end else if (w_halted) begin
            w_en    = '0;
        end else if (w_stall_mode) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k <= int'(w_s.idx))     w_en[k]    = 1'b0;
                if (k == int'(w_s.idx) + 1) w_flush[k] = 1'b1;
            end
        end else if (w_flush_mode) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (k <= int'(w_f.idx)) w_flush[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_flush[IF_STG])   w_valid_nxt[IF_STG] = 1'b0;
        else if (w_en[IF_STG]) w_valid_nxt[IF_STG] = bus.inst_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (w_flush[k])   w_valid_nxt[k] = 1'b0;
            else if (w_en[k]) w_valid_nxt[k] = r_valid[k-1];
        end
    end

    assign w_stall_inc = ~(&w_en) & ~w_halted;
    assign w_flush_inc = w_flush_mode & ~w_halted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid        <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_stall_inc && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_flush_inc && (r_flush_count != '1))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign bus.stage_en     = w_en;
    assign bus.stage_flush  = w_flush;
    assign bus.stage_valid  = r_valid;
    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;

endmodule
`default_nettype wire
